mul_unit: RTL and testbench
===========================

# mul_unit

Issue and result-select stage for the RV32M multiply instructions. Sits directly upstream of the two-operand `multiply` block:
- accepts MUL/MULH/MULHSU/MULHU requests from the execute stage;
- drives the multiplier's `stb`/`ack` handshake and selects the low or high half of its product;
- applies the MULHSU sign correction;
- returns the XLEN-bit result on a valid/ready port.

It keeps the last full product so that a MULH[[S]U]/MUL pair on the same operands costs one multiplier pass.

## Interface
- `XLEN`, 32, operand and result width; the multiplier product is 2*XLEN.

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_op`  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
- `req_a`, `req_b`  in  XLEN  rs1, rs2 values
- `resp_valid`  out  1  result present
- `resp_ready`  in  1  consumer takes result
- `resp_data`  out  XLEN  result
- `mul_a`, `mul_b`  out  XLEN  multiplier operands
- `mul_is_signed`  out  1  multiplier signedness (both operands)
- `mul_stb`  out  1  start pulse to multiplier
- `mul_o`  in  2*XLEN  multiplier product, valid in the `mul_ack` cycle
- `mul_ack`  in  1  one-cycle completion pulse from multiplier

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: register op, a and b, then check the product cache.
  - Hit: go to RESP and compute the result from the cached product.
  - Miss: go to ISSUE.
- **ISSUE**
  - `mul_stb`=1 for exactly this cycle, then go to WAIT.
  - `mul_a`/`mul_b`/`mul_is_signed` come from registers and stay stable from ISSUE until `mul_ack`.
- **WAIT**
  - On `mul_ack`: store `mul_o`, the operands and the signedness into the cache; set cache valid; register the result; go to RESP.
  - An ack arriving in the ISSUE cycle is also honoured.
- **RESP**
  - `resp_valid`=1 and `resp_data` is held stable.
  - On `resp_ready`: go to IDLE.
  - `req_ready`=0 in every state except IDLE.
- **Signedness issued**
  - MULH: signed.
  - MUL, MULHU, MULHSU: unsigned.
- **Result select** (P = 2*XLEN product)
  - MUL: P[XLEN-1:0].
  - MULH, MULHU: P[2*XLEN-1:XLEN].
  - MULHSU: P_unsigned[2*XLEN-1:XLEN] − (a[XLEN-1] ? b : 0), modulo 2^XLEN.
- **Cache hit rule** (cache valid, a and b equal to the cached operands, and):
  - MUL: any cached signedness, since the low half is sign-independent.
  - MULH: cached signed.
  - MULHU, MULHSU: cached unsigned.
- The cache holds one entry and is overwritten on every multiplier completion.

## Timing
- Reset values: state IDLE; `req_ready`=1 in the cycle after reset; `resp_valid`=0, `resp_data`=0, `mul_stb`=0; `mul_a`=`mul_b`=0; `mul_is_signed`=0; cache invalid.
- Cycles counted from the accept cycle t:
  - Miss: `mul_stb` at t+1. If `mul_ack` arrives at cycle k, `resp_valid` is set from k+1.
  - Hit: `resp_valid` at t+1 and no `mul_stb` is issued.
- Throughput is one request in flight. The next accept happens no earlier than the cycle after the resp handshake.
- `rst` asserted in any state:
  - next state IDLE and cache invalidated;
  - `resp_valid` and `mul_stb` drop the next cycle;
  - a stale `mul_ack` while IDLE is ignored.
- `req_*` inputs are ignored outside IDLE.
- `mul_ack` in IDLE or RESP is ignored.

## Test plan
- **MUL miss:** MUL a=7, b=6 from reset.
  - `mul_stb` one cycle at t+1, `mul_is_signed`=0.
  - `resp_data`=42 the cycle after `mul_ack`.
- **MULH/MULHU:** MULH then MULHU, both a=b=0xFFFFFFFF.
  - MULH → 0x00000000.
  - MULHU misses (signedness differs) → 0xFFFFFFFE; two `mul_stb` pulses in total.
- **MULHSU correction:**
  - a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
  - a=0x00000003, b=0x80000000 → 0x00000001.
- **Cache hit:** MULH a=0x12345678, b=0x9ABCDEF0, then MUL with the same operands.
  - MUL `resp_valid` at t+1 with no `mul_stb`.
  - `resp_data`=0x242D2080.
- **Backpressure:** hold `resp_ready`=0 for 3 cycles in RESP.
  - `resp_valid` and `resp_data` stay stable; `req_ready`=0.
  - A request presented during that time is not accepted.
- **Reset mid-WAIT:** assert `rst` during WAIT.
  - Next cycle IDLE and `req_ready`=1.
  - A repeat of the same operands misses (new `mul_stb`).

Source files
------------

// File: rtl/mul_unit.sv
// RV32M multiply issue/result-select stage: drives the external multiplier handshake,
// picks the product half, applies the MULHSU correction and keeps a one-entry product cache.
module mul_unit #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  output logic              mul_is_signed,
  output logic              mul_stb,
  input  logic [2*XLEN-1:0] mul_o,
  input  logic              mul_ack
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;

  logic [1:0]        state;
  logic [1:0]        op_p0;
  logic [XLEN-1:0]   a_p0;
  logic [XLEN-1:0]   b_p0;
  logic              cache_vld;
  logic              cache_signed;
  logic [XLEN-1:0]   cache_a;
  logic [XLEN-1:0]   cache_b;
  logic [2*XLEN-1:0] cache_p;
  logic              hit;
  logic              done;
  logic [XLEN-1:0]   hit_res;
  logic [XLEN-1:0]   ack_res;

  // MULHSU is issued unsigned; subtracting b when a is negative turns a*b into (signed a)*b.
  function automatic logic [XLEN-1:0] select_result(input logic [1:0] op,
                                                    input logic [2*XLEN-1:0] p,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
    logic [XLEN-1:0] hi;
    hi = p[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:    return p[XLEN-1:0];
      OP_MULHSU: return hi - (a[XLEN-1] ? b : '0);
      default:   return hi;
    endcase
  endfunction

  // The low half is sign-independent, so MUL hits on either cached signedness.
  always_comb begin
    hit = cache_vld && (req_a == cache_a) && (req_b == cache_b) &&
          ((req_op == OP_MUL) || ((req_op == OP_MULH) == cache_signed));
  end

  assign hit_res       = select_result(req_op, cache_p, req_a, req_b);
  assign ack_res       = select_result(op_p0, mul_o, a_p0, b_p0);
  assign done          = ((state == ISSUE) || (state == WAIT)) && mul_ack;
  assign req_ready     = (state == IDLE);
  assign resp_valid    = (state == RESP);
  assign mul_stb       = (state == ISSUE);
  assign mul_a         = a_p0;
  assign mul_b         = b_p0;
  assign mul_is_signed = (op_p0 == OP_MULH);

  // Stage p0: request capture, multiplier wait and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cache_vld <= 1'b0;
      op_p0     <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      resp_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_p0 <= req_op;
            a_p0  <= req_a;
            b_p0  <= req_b;
            if (hit) begin
              resp_data <= hit_res;
              state     <= RESP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE, WAIT: begin
          if (mul_ack) begin
            resp_data <= ack_res;
            cache_vld <= 1'b1;
            state     <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        default: begin
          if (resp_ready) state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && done) begin
      cache_p      <= mul_o;
      cache_a      <= a_p0;
      cache_b      <= b_p0;
      cache_signed <= (op_p0 == OP_MULH);
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: a behavioural multiplier with programmable ack latency plus
// directed and randomized requests checked against a plain-arithmetic result model.
module tb_mul_unit;
  localparam int XLEN = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [XLEN-1:0]  mul_a;
  logic [XLEN-1:0]  mul_b;
  logic             mul_is_signed;
  logic             mul_stb;
  logic [63:0]      mul_o = '0;
  logic             mul_ack = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  int          lat = 1;
  int          cnt = 0;
  int          stb_count = 0;
  logic [63:0] prod = '0;
  logic        last_signed = 1'b0;

  always #5 clk = ~clk;

  mul_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_is_signed(mul_is_signed),
    .mul_stb(mul_stb), .mul_o(mul_o), .mul_ack(mul_ack)
  );

  // Multiplier stand-in: latency 0 acks in the strobe cycle itself.
  always @(negedge clk) begin
    mul_ack = 1'b0;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        mul_ack = 1'b1;
        mul_o   = prod;
      end
    end else if (mul_stb) begin
      stb_count   = stb_count + 1;
      last_signed = mul_is_signed;
      if (mul_is_signed)
        prod = 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
      else
        prod = {32'b0, mul_a} * {32'b0, mul_b};
      if (lat == 0) begin
        mul_ack = 1'b1;
        mul_o   = prod;
      end else begin
        cnt = lat;
      end
    end
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      2'd0:    p = 64'(ua * ub);
      2'd1:    p = 64'(sa * sb);
      2'd2:    p = 64'(sa * ub);
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int l);
    lat = l;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  // Returns the cycle (relative to the accept cycle) at which resp_valid was seen.
  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!resp_valid && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic finish_resp(input int stall);
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int l, input int stall, output logic [31:0] res,
                         output int cyc, output int nstb);
    int s0;
    s0 = stb_count;
    start_req(op, a, b, l);
    wait_resp(cyc);
    res  = resp_data;
    nstb = stb_count - s0;
    finish_resp(stall);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    n_checks++; if (mul_stb !== 1'b0) begin n_fail++; $display("FAIL reset_mul_stb: got %b want 0", mul_stb); end
    n_checks++; if (mul_a !== 32'h0 || mul_b !== 32'h0) begin n_fail++; $display("FAIL reset_mul_ab: got %h %h want 0 0", mul_a, mul_b); end
    n_checks++; if (mul_is_signed !== 1'b0) begin n_fail++; $display("FAIL reset_mul_is_signed: got %b want 0", mul_is_signed); end
  endtask

  task automatic test_mul_miss();
    logic [31:0] res;
    int cyc, nstb;
    run_txn(2'd0, 32'd7, 32'd6, 2, 0, res, cyc, nstb);
    n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL mul_miss_data: got %0d want 42", res); end
    n_checks++; if (nstb != 1) begin n_fail++; $display("FAIL mul_miss_stb: got %0d pulses want 1", nstb); end
    n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL mul_miss_latency: got t+%0d want t+4", cyc); end
    n_checks++; if (last_signed !== 1'b0) begin n_fail++; $display("FAIL mul_miss_signed: got %b want 0", last_signed); end
  endtask

  task automatic test_mulh_mulhu();
    logic [31:0] res;
    int cyc, nstb;
    run_txn(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, res, cyc, nstb);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL mulh_data: got %h want 00000000", res); end
    n_checks++; if (last_signed !== 1'b1) begin n_fail++; $display("FAIL mulh_signed: got %b want 1", last_signed); end
    n_checks++; if (cyc != 3 || nstb != 1) begin n_fail++; $display("FAIL mulh_issue: got t+%0d/%0d stb want t+3/1", cyc, nstb); end
    run_txn(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, res, cyc, nstb);
    n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_data: got %h want fffffffe", res); end
    n_checks++; if (nstb != 1 || last_signed !== 1'b0) begin n_fail++; $display("FAIL mulhu_miss: got %0d stb signed=%b want 1 stb signed=0", nstb, last_signed); end
  endtask

  task automatic test_mulhsu();
    logic [31:0] res;
    int cyc, nstb;
    run_txn(2'd2, 32'hFFFF_FFFF, 32'd2, 0, 0, res, cyc, nstb);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_neg: got %h want ffffffff", res); end
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL mulhsu_ack_in_issue: got t+%0d want t+2", cyc); end
    run_txn(2'd2, 32'd3, 32'h8000_0000, 0, 0, res, cyc, nstb);
    n_checks++; if (res !== 32'h1) begin n_fail++; $display("FAIL mulhsu_pos: got %h want 00000001", res); end
  endtask

  task automatic test_cache_hit();
    logic [31:0] res;
    int cyc, nstb;
    run_txn(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 3, 0, res, cyc, nstb);
    n_checks++; if (res !== ref_mul(2'd1, 32'h1234_5678, 32'h9ABC_DEF0)) begin n_fail++; $display("FAIL hit_prime_mulh: got %h want %h", res, ref_mul(2'd1, 32'h1234_5678, 32'h9ABC_DEF0)); end
    run_txn(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 3, 0, res, cyc, nstb);
    n_checks++; if (res !== 32'h242D_2080) begin n_fail++; $display("FAIL hit_mul_data: got %h want 242d2080", res); end
    n_checks++; if (cyc != 1 || nstb != 0) begin n_fail++; $display("FAIL hit_mul_timing: got t+%0d/%0d stb want t+1/0", cyc, nstb); end
    run_txn(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0, res, cyc, nstb);
    n_checks++; if (nstb != 1 || res !== ref_mul(2'd3, 32'h1234_5678, 32'h9ABC_DEF0)) begin n_fail++; $display("FAIL hit_mulhu_miss: got %h/%0d stb want %h/1", res, nstb, ref_mul(2'd3, 32'h1234_5678, 32'h9ABC_DEF0)); end
    run_txn(2'd2, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0, res, cyc, nstb);
    n_checks++; if (nstb != 0 || cyc != 1 || res !== ref_mul(2'd2, 32'h1234_5678, 32'h9ABC_DEF0)) begin n_fail++; $display("FAIL hit_mulhsu: got %h/%0d stb/t+%0d want %h/0/t+1", res, nstb, cyc, ref_mul(2'd2, 32'h1234_5678, 32'h9ABC_DEF0)); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, d;
    int cyc, s0, bad;
    a = $urandom;
    b = $urandom;
    start_req(2'd0, a, b, 1);
    wait_resp(cyc);
    d  = resp_data;
    s0 = stb_count;
    n_checks++; if (d !== ref_mul(2'd0, a, b)) begin n_fail++; $display("FAIL bp_data: got %h want %h", d, ref_mul(2'd0, a, b)); end
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_a     = ~a;
    req_b     = ~b;
    bad = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b1 || resp_data !== d || req_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0 (valid=%b data=%h ready=%b)", bad, resp_valid, resp_data, req_ready); end
    req_valid = 1'b0;
    finish_resp(0);
    n_checks++; if (req_ready !== 1'b1 || stb_count != s0) begin n_fail++; $display("FAIL bp_ignored_req: ready=%b extra stb=%0d want 1/0", req_ready, stb_count - s0); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a, b, res;
    int cyc, nstb, bad;
    a = $urandom;
    b = $urandom;
    start_req(2'd3, a, b, 6);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mul_stb !== 1'b0) begin n_fail++; $display("FAIL rst_wait_idle: ready=%b valid=%b stb=%b want 1/0/0", req_ready, resp_valid, mul_stb); end
    bad = 0;
    repeat (7) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rst_stale_ack: got %0d bad cycles want 0", bad); end
    run_txn(2'd3, a, b, 1, 0, res, cyc, nstb);
    n_checks++; if (nstb != 1 || res !== ref_mul(2'd3, a, b)) begin n_fail++; $display("FAIL rst_repeat_miss: got %h/%0d stb want %h/1", res, nstb, ref_mul(2'd3, a, b)); end
  endtask

  task automatic test_random();
    logic        cvalid, csigned, hit;
    logic [31:0] ca, cb, a, b, res, exp;
    logic [1:0]  op;
    int          l, cyc, nstb, ecyc;
    apply_reset();
    cvalid = 1'b0; csigned = 1'b0; ca = '0; cb = '0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        1, 2:    begin a = cvalid ? ca : $urandom; b = cvalid ? cb : $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      op  = 2'($urandom);
      l   = $urandom_range(0, 3);
      hit = cvalid && a == ca && b == cb && (op == 2'd0 || ((op == 2'd1) == csigned));
      exp = ref_mul(op, a, b);
      ecyc = hit ? 1 : 2 + l;
      run_txn(op, a, b, l, $urandom_range(0, 2), res, cyc, nstb);
      n_checks++; if (res !== exp) begin n_fail++; $display("FAIL rand_data[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp); end
      n_checks++; if (nstb != (hit ? 0 : 1) || cyc != ecyc) begin n_fail++; $display("FAIL rand_timing[%0d]: got %0d stb t+%0d want %0d stb t+%0d", i, nstb, cyc, hit ? 0 : 1, ecyc); end
      if (!hit) begin
        cvalid = 1'b1; ca = a; cb = b; csigned = (op == 2'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    test_reset();
    test_mul_miss();
    test_mulh_mulhu();
    test_mulhsu();
    test_cache_hit();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_checks);
    $fatal(1, "timeout");
  end

endmodule
